// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I sequencing controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    JAL      = 4'd8,
    BEQ      = 4'd9,
    ALUWB    = 4'd10
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: wraps modulo 2^W, cleared asynchronously.
module instret_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (en)  count <= count + W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multicycle RV32I core: datapath muxes,
// enables, memory-ready stalls and retired-instruction count.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ResultSrc,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  ctrl_state_t state, state_nxt;
  logic        pc_update;
  logic        branch;
  logic        retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  // Next state and Moore decode; mem_ready/Zero/op only gate the few outputs that need them.
  always_comb begin
    state_nxt = state;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    illegal   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_JAL:            state_nxt = JAL;
          OP_BRANCH:         state_nxt = BEQ;
          default: begin
            state_nxt = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA   = SRCA_RD1;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RD1;
        ALUOp     = ALUOP_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  instret_counter #(.W(INSTRET_W)) u_instret (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (retire),
    .count   (instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs queued and checked.
module tb_multicycle_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [6:0]   op;
  logic         Zero;
  logic         mem_ready;
  logic         AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
  logic [1:0]   ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [W-1:0] instret;

  multicycle_ctrl #(.INSTRET_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .illegal   (illegal),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_J, T_B, T_AW} st_t;

  typedef struct {
    string        tag;
    logic [15:0]  outs;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] exp_cnt = '0;
  logic [15:0] obs;

  assign obs = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                PCWrite, RegWrite, MemWrite, illegal};

  localparam logic [6:0] L_LW  = 7'b0000011;
  localparam logic [6:0] L_SW  = 7'b0100011;
  localparam logic [6:0] L_R   = 7'b0110011;
  localparam logic [6:0] L_I   = 7'b0010011;
  localparam logic [6:0] L_JAL = 7'b1101111;
  localparam logic [6:0] L_BEQ = 7'b1100011;
  localparam logic [6:0] L_BAD = 7'b1111111;

  // Expected output vector for a given state and inputs.
  function automatic logic [15:0] exp_outs(st_t s, logic [6:0] o, logic mr, logic z);
    logic adr, irw, pcw, rw, mw, ill;
    logic [1:0] a, b, aop, res;
    adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
    a = 2'b00; b = 2'b00; aop = 2'b00; res = 2'b00;
    case (s)
      T_F:   begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      T_D:   begin a = 2'b01; b = 2'b01;
                   ill = !(o inside {L_LW, L_SW, L_R, L_I, L_JAL, L_BEQ}); end
      T_MA:  begin a = 2'b10; b = 2'b01; end
      T_MR:  begin adr = 1; end
      T_MWB: begin res = 2'b01; rw = 1; end
      T_MW:  begin adr = 1; mw = 1; end
      T_ER:  begin a = 2'b10; aop = 2'b10; end
      T_EI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      T_J:   begin a = 2'b01; b = 2'b10; pcw = 1; end
      T_B:   begin a = 2'b10; aop = 2'b01; pcw = z; end
      T_AW:  begin rw = 1; end
      default: ;
    endcase
    return {adr, irw, a, b, aop, res, pcw, rw, mw, ill};
  endfunction

  function automatic bit retires(st_t s, logic mr);
    return (s == T_MWB) || (s == T_AW) || (s == T_B) || (s == T_MW && mr);
  endfunction

  task automatic check_head();
    exp_t e;
    e = sbq.pop_front();
    total++;
    assert (obs === e.outs) else begin
      bad++;
      $error("FAIL %s outs observed=%b expected=%b", e.tag, obs, e.outs);
    end
    total++;
    assert (instret === e.cnt) else begin
      bad++;
      $error("FAIL %s instret observed=%0d expected=%0d", e.tag, instret, e.cnt);
    end
  endtask

  // One clock cycle in a known state; called just after a rising edge.
  task automatic cyc(input string tag, input st_t s, input logic [6:0] o,
                     input logic mr, input logic z);
    exp_t e;
    op = o; mem_ready = mr; Zero = z;
    e.tag = tag; e.outs = exp_outs(s, o, mr, z); e.cnt = exp_cnt;
    sbq.push_back(e);
    @(negedge clk);
    check_head();
    if (retires(s, mr)) exp_cnt = exp_cnt + W'(1);
    @(posedge clk);
    #1;
  endtask

  // Immediate check without advancing the clock.
  task automatic chk_now(input string tag, input st_t s, input logic [6:0] o,
                         input logic mr, input logic z, input logic [W-1:0] cnt);
    exp_t e;
    op = o; mem_ready = mr; Zero = z;
    #1;
    e.tag = tag; e.outs = exp_outs(s, o, mr, z); e.cnt = cnt;
    sbq.push_back(e);
    check_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; op = '0; Zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk_now("rst_mr1", T_F, L_BAD, 1'b1, 1'b1, '0);
    chk_now("rst_mr0", T_F, L_BAD, 1'b0, 1'b1, '0);
    @(posedge clk); #1;
    chk_now("rst_hold", T_F, L_R, 1'b1, 1'b0, '0);
    reset_n = 1'b1;

    // R-type
    cyc("r_f",  T_F,  L_R, 1, 1);
    cyc("r_d",  T_D,  L_R, 0, 1);
    cyc("r_ex", T_ER, L_R, 0, 1);
    cyc("r_wb", T_AW, L_R, 0, 1);

    // lw with three MEMREAD stall cycles
    cyc("lw_f",   T_F,   L_LW, 1, 1);
    cyc("lw_d",   T_D,   L_LW, 0, 1);
    cyc("lw_ma",  T_MA,  L_LW, 0, 1);
    cyc("lw_mr0", T_MR,  L_LW, 0, 1);
    cyc("lw_mr1", T_MR,  L_LW, 0, 1);
    cyc("lw_mr2", T_MR,  L_LW, 0, 1);
    cyc("lw_mr3", T_MR,  L_LW, 1, 1);
    cyc("lw_wb",  T_MWB, L_LW, 0, 1);

    // beq taken then not taken
    cyc("beq1_f", T_F, L_BEQ, 1, 0);
    cyc("beq1_d", T_D, L_BEQ, 1, 1);
    cyc("beq1_b", T_B, L_BEQ, 1, 1);
    cyc("beq0_f", T_F, L_BEQ, 1, 1);
    cyc("beq0_d", T_D, L_BEQ, 1, 1);
    cyc("beq0_b", T_B, L_BEQ, 1, 0);

    // sw with two-cycle stall
    cyc("sw_f",   T_F,  L_SW, 1, 1);
    cyc("sw_d",   T_D,  L_SW, 1, 1);
    cyc("sw_ma",  T_MA, L_SW, 1, 1);
    cyc("sw_mw0", T_MW, L_SW, 0, 1);
    cyc("sw_mw1", T_MW, L_SW, 0, 1);
    cyc("sw_mw2", T_MW, L_SW, 1, 1);

    // jal, I-type with fetch stalls
    cyc("jal_f",  T_F,  L_JAL, 1, 0);
    cyc("jal_d",  T_D,  L_JAL, 1, 0);
    cyc("jal_j",  T_J,  L_JAL, 0, 0);
    cyc("jal_wb", T_AW, L_JAL, 0, 1);
    cyc("i_fs0",  T_F,  L_I,   0, 1);
    cyc("i_fs1",  T_F,  L_I,   0, 0);
    cyc("i_f",    T_F,  L_I,   1, 0);
    cyc("i_d",    T_D,  L_I,   1, 1);
    cyc("i_ex",   T_EI, L_I,   1, 1);
    cyc("i_wb",   T_AW, L_I,   1, 1);

    // illegal opcodes do not retire
    cyc("ill_f",  T_F, L_BAD, 1, 1);
    cyc("ill_d",  T_D, L_BAD, 1, 1);
    cyc("ill2_f", T_F, 7'b0110111, 1, 1);
    cyc("ill2_d", T_D, 7'b0110111, 0, 1);

    // async reset in the middle of EXECI
    cyc("ar_f", T_F, L_I, 1, 1);
    cyc("ar_d", T_D, L_I, 1, 1);
    op = L_I; mem_ready = 1'b1; Zero = 1'b1;
    begin
      exp_t e;
      e.tag = "ar_ex"; e.outs = exp_outs(T_EI, L_I, 1, 1); e.cnt = exp_cnt;
      sbq.push_back(e);
    end
    @(negedge clk);
    check_head();
    #2 reset_n = 1'b0;
    chk_now("ar_async", T_F, L_I, 1'b1, 1'b1, '0);
    exp_cnt = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 16 retires wrap a 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      cyc("wr_f", T_F, L_BEQ, 1, 0);
      cyc("wr_d", T_D, L_BEQ, 1, 0);
      cyc("wr_b", T_B, L_BEQ, 1, k[0]);
    end
    chk_now("wrap", T_F, L_R, 1'b0, 1'b0, '0);
    cyc("post_f", T_F, L_R, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main sequencing controller for the multicycle RV32I core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback, driving the shared ALU's operand muxes and `ALUOp`. `ALUOp` feeds the existing ALU decoder, which produces the final ALU control. The controller also drives the register-file, instruction-register, PC and memory enables, stalls on a memory-ready handshake, and counts retired instructions.

## Interface
Parameters:
- `INSTRET_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode from the instruction register; valid from Decode onward.
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `IRWrite`  out  1  load the instruction register.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = decode funct3/funct7.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `PCWrite`  out  1  PC enable; equals `PCUpdate | (Branch & Zero)`.
- `RegWrite`  out  1  register-file write enable.
- `MemWrite`  out  1  data-memory write enable.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, BEQ, ALUWB.
- Outputs not listed for a state are 0.
- FETCH: `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `AdrSrc`=0.
  - `IRWrite` and `PCUpdate` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch-target precompute). Next state by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1101111 → JAL.
  - 1100011 → BEQ.
  - Any other opcode → FETCH, with `illegal`=1 for this cycle.
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: `ResultSrc`=00, `AdrSrc`=1. Holds until `mem_ready`, then → MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1. `MemWrite` is held through stall cycles. → FETCH when `mem_ready`.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10 → ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10 → ALUWB.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1 → ALUWB.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1 → FETCH.
- ALUWB: `ResultSrc`=00, `RegWrite`=1 → FETCH.
- `instret` increments by 1 on every exit from MEMWB, ALUWB, BEQ, or MEMWRITE (the latter only with `mem_ready`=1).
  - Wraps modulo 2^`INSTRET_W`.
  - Illegal opcodes do not count.

## Timing
- Reset is asynchronous: `reset_n`=0 immediately forces state to FETCH and `instret` to 0.
  - While in reset, outputs are the FETCH decode with `IRWrite`=`PCUpdate`=`mem_ready`.
  - Reset asserted mid-instruction abandons the instruction; there is no partial retire.
- All outputs are combinational from state only, except three, which are registered-state Moore outputs gated combinationally by inputs:
  - `PCWrite` (uses `Zero`).
  - `IRWrite` (uses `mem_ready`).
  - `illegal` (uses `op`).
- Cycle counts with `mem_ready` tied to 1:
  - R-type, I-type: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - jal: 4 cycles.
  - beq: 3 cycles.
  - illegal: 2 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle. No other state samples `mem_ready`.
- `Zero` is sampled only in BEQ; `PCWrite` never glitches to 1 in other states.

## Structure
- Shared package `ctrl_pkg`:
  - state enum `ctrl_state_t`.
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_JAL`, `OP_BRANCH`.
  - `ALUSrcA`, `ALUSrcB`, `ResultSrc` and `ALUOp` encoding constants.
- One sub-module, `instret_counter`: the enable-driven wrapping counter with async active-low clear.
- Everything else is in one state register plus next-state and output logic.

## Test plan
- Reset, then R-type op 0110011 with `mem_ready`=1 → state sequence FETCH, DECODE, EXECR, ALUWB, FETCH.
  - `RegWrite`=1 only in cycle 4.
  - `instret`=1 after that cycle.
- lw with `mem_ready` held 0 for 3 cycles in MEMREAD → 8 cycles total; `AdrSrc`=1 throughout MEMREAD; `RegWrite` only in MEMWB.
- beq with `Zero`=1 → `PCWrite`=1 in the BEQ cycle.
  - With `Zero`=0 → `PCWrite`=0.
  - Either case returns to FETCH after 3 cycles, `instret`+1.
- sw with a 2-cycle stall → `MemWrite`=1 for 3 consecutive cycles, then FETCH; `RegWrite` is never asserted.
- op 1111111 → `illegal` is a 1-cycle pulse in DECODE, next state FETCH, `instret` unchanged.
- Drop `reset_n` mid-EXECI → FETCH immediately (asynchronously, before the next clock edge), `instret`=0; with `INSTRET_W`=4, 16 retires wrap the counter to 0.
